// File: rtl/sprite_rom_arbiter.sv
// Round-robin req/ack arbiter sharing one combinational sprite-bitmap ROM between N_REQ renderers.
// Define SPRITE_ARB_FIXED_PRI_EN for fixed priority (requester 0 highest, no rotating pointer).
module sprite_rom_arbiter #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned AW    = 8,
    parameter int unsigned DW    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*AW-1:0] addr,
    output logic [DW-1:0]       rdata,
    output logic [N_REQ-1:0]    ack,
    output logic [1:0]          grant_id,
    output logic                busy,
    output logic [AW-1:0]       rom_addr,
    input  logic [DW-1:0]       rom_bits
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ACK   = 2'd2;

    logic [1:0]       state_q,    state_d;
    logic [1:0]       grant_q,    grant_d;
    logic [AW-1:0]    rom_addr_q, rom_addr_d;
    logic [DW-1:0]    rdata_q,    rdata_d;
    logic [N_REQ-1:0] ack_q,      ack_d;

    logic             win_valid;
    logic [1:0]       win_id;
    logic [AW-1:0]    win_addr;
    logic [N_REQ-1:0] grant_onehot;

    // Returns {found, index} of the lowest set bit.
    function automatic logic [2:0] pick_lowest(input logic [N_REQ-1:0] v);
        logic [2:0] r;
        r = '0;
        for (int unsigned k = N_REQ; k > 0; k--) begin
            if (v[k-1]) r = {1'b1, 2'(k-1)};
        end
        return r;
    endfunction

`ifdef SPRITE_ARB_FIXED_PRI_EN
    always_comb begin
        {win_valid, win_id} = pick_lowest(req);
    end
`else
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0] hi_mask;
    logic [2:0]       pick_hi, pick_all;

    // Circular search: prefer requests at or above the pointer, else wrap to the lowest.
    always_comb begin
        hi_mask = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            hi_mask[k] = (k >= 32'(rr_ptr_q));
        end
        pick_hi  = pick_lowest(req & hi_mask);
        pick_all = pick_lowest(req);
        {win_valid, win_id} = pick_hi[2] ? pick_hi : pick_all;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == S_ACK) begin
            rr_ptr_d = (32'(grant_q) == N_REQ - 1) ? 2'd0 : grant_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end
`endif

    always_comb begin
        win_addr     = '0;
        grant_onehot = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (win_id == 2'(k))  win_addr = addr[k*AW +: AW];
            grant_onehot[k] = (grant_q == 2'(k));
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rom_addr_d = rom_addr_q;
        rdata_d    = rdata_q;
        ack_d      = ack_q;
        case (state_q)
            S_IDLE: begin
                if (win_valid) begin
                    grant_d    = win_id;
                    rom_addr_d = win_addr;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                rdata_d = rom_bits;
                ack_d   = grant_onehot;
                state_d = S_ACK;
            end
            S_ACK: begin
                ack_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                ack_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            rom_addr_q <= '0;
            rdata_q    <= '0;
            ack_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rom_addr_q <= rom_addr_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
        end
    end

    assign rdata    = rdata_q;
    assign ack      = ack_q;
    assign grant_id = grant_q;
    assign busy     = (state_q == S_FETCH) || (state_q == S_ACK);
    assign rom_addr = rom_addr_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter (2 requesters, tank bitmap ROM model).
// Expected arbitration follows SPRITE_ARB_FIXED_PRI_EN when that macro is defined.
module tb_sprite_rom_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [7:0]  addr0, addr1;
    logic [7:0]  rdata;
    logic [1:0]  ack;
    logic [1:0]  grant_id;
    logic        busy;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_bits;

    typedef struct packed {
        logic [1:0] g;
        logic [1:0] ack;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_errors;
    int   acks_seen;
    logic [1:0] model_rr;
    logic [1:0] prev_ack;

    sprite_rom_arbiter #(.N_REQ(2), .AW(8), .DW(8)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .req      (req),
        .addr     ({addr1, addr0}),
        .rdata    (rdata),
        .ack      (ack),
        .grant_id (grant_id),
        .busy     (busy),
        .rom_addr (rom_addr),
        .rom_bits (rom_bits)
    );

    function automatic logic [7:0] rom_fn(input logic [7:0] a);
        case (a)
            8'h00:   return 8'h80;
            8'h01:   return 8'h07;
            8'h87:   return 8'h0F;
            default: return a ^ 8'h5A;
        endcase
    endfunction

    assign rom_bits = rom_fn(rom_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference winner choice for two requesters.
    function automatic logic [1:0] model_pick(input logic [1:0] r, input logic [1:0] p);
`ifdef SPRITE_ARB_FIXED_PRI_EN
        return r[0] ? 2'd0 : 2'd1;
`else
        if (r[p[0]]) return p;
        return {1'b0, ~p[0]};
`endif
    endfunction

    task automatic push_expect(input logic [1:0] r, input logic [7:0] a0, input logic [7:0] a1);
        exp_t e;
        e.g    = model_pick(r, model_rr);
        e.ack  = (e.g == 2'd0) ? 2'b01 : 2'b10;
        e.data = rom_fn((e.g == 2'd0) ? a0 : a1);
        sb.push_back(e);
        model_rr = (e.g == 2'd1) ? 2'd0 : 2'd1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (ack != 2'b00) begin
                check("ack_pulse_width", 32'(prev_ack), 32'(0));
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'(ack), 32'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ack",      32'(ack),      32'(e.ack));
                    check("rdata",    32'(rdata),    32'(e.data));
                    check("grant_id", 32'(grant_id), 32'(e.g));
                end
                acks_seen++;
            end
            prev_ack = ack;
        end else begin
            prev_ack = 2'b00;
        end
    end

    task automatic wait_ack_count(input int target);
        for (int c = 0; c < 60 && acks_seen < target; c++) begin
            @(negedge clk);
            #1;
        end
        if (acks_seen < target) check("ack_timeout", 32'(acks_seen), 32'(target));
    endtask

    // Hold a request pattern for n transactions, then release it during the last ACK.
    task automatic run_phase(input logic [1:0] r, input logic [7:0] a0, input logic [7:0] a1,
                             input int n);
        int base;
        addr0 = a0;
        addr1 = a1;
        for (int i = 0; i < n; i++) push_expect(r, a0, a1);
        base = acks_seen;
        req  = r;
        wait_ack_count(base + n);
        req = 2'b00;
        @(negedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        acks_seen = 0;
        model_rr  = 2'd0;
        prev_ack  = 2'b00;
        rst_n     = 1'b0;
        req       = 2'b11;
        addr0     = 8'h00;
        addr1     = 8'h87;

        // Reset held with both requests pending.
        repeat (3) begin
            @(negedge clk);
            #1;
            check("rst_ack",      32'(ack),      32'(0));
            check("rst_busy",     32'(busy),     32'(0));
            check("rst_rom_addr", 32'(rom_addr), 32'(0));
        end
        check("rst_rdata", 32'(rdata),    32'(0));
        check("rst_grant", 32'(grant_id), 32'(0));
        push_expect(2'b11, 8'h00, 8'h87);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("first_grant", 32'(grant_id), 32'(0));
        check("first_busy",  32'(busy),     32'(1));
        wait_ack_count(1);
        req = 2'b00;
        @(negedge clk);
        #1;

        // Single fetch: exact latency and busy window.
        addr0 = 8'h01;
        push_expect(2'b01, 8'h01, addr1);
        req = 2'b01;
        @(negedge clk);
        #1;
        check("t2_fetch_busy", 32'(busy), 32'(1));
        check("t2_fetch_ack",  32'(ack),  32'(0));
        @(negedge clk);
        #1;
        check("t2_ack",       32'(ack),   32'(2'b01));
        check("t2_ack_busy",  32'(busy),  32'(1));
        check("t2_rdata",     32'(rdata), 32'(8'h07));
        req = 2'b00;
        @(negedge clk);
        #1;
        check("t2_idle_busy", 32'(busy), 32'(0));
        check("t2_idle_ack",  32'(ack),  32'(0));

        // Idle: rom_addr and rdata hold their last values.
        repeat (3) @(negedge clk);
        #1;
        check("idle_rom_addr", 32'(rom_addr), 32'(8'h01));
        check("idle_rdata",    32'(rdata),    32'(8'h07));

        // Both requesting continuously, then requester 0 backs off.
        run_phase(2'b11, 8'h00, 8'h87, 4);
        run_phase(2'b10, 8'h00, 8'h87, 1);
        run_phase(2'b01, 8'h55, 8'h87, 2);

        // Address and request change during FETCH use the latched address.
        addr0 = 8'h00;
        push_expect(2'b01, 8'h00, addr1);
        req = 2'b01;
        @(negedge clk);
        #1;
        addr0 = 8'h01;
        req   = 2'b00;
        wait_ack_count(acks_seen + 1);
        @(negedge clk);
        #1;

        // Reset asserted mid-transaction abandons it; pending request is re-served.
        addr1 = 8'h87;
        req   = 2'b10;
        @(negedge clk);
        #1;
        check("t6_fetch_busy", 32'(busy), 32'(1));
        rst_n = 1'b0;
        #1;
        check("t6_rst_ack",   32'(ack),      32'(0));
        check("t6_rst_busy",  32'(busy),     32'(0));
        check("t6_rst_addr",  32'(rom_addr), 32'(0));
        @(negedge clk);
        #1;
        check("t6_rst_ack2",  32'(ack),   32'(0));
        check("t6_rst_rdata", 32'(rdata), 32'(0));
        model_rr = 2'd0;
        push_expect(2'b10, addr0, 8'h87);
        rst_n = 1'b1;
        wait_ack_count(acks_seen + 1);
        req = 2'b00;
        repeat (2) @(negedge clk);
        #1;

        check("sb_empty", 32'(sb.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
